xorshift_rng: RTL and testbench
===============================

# xorshift_rng

Parametrised xorshift pseudo-random generator for the MIPS-E peripheral set. It generalises the fixed 32-bit free-running generator with several additions:
- selectable width and shift constants;
- a runtime seed load with a zero-seed guard;
- a consumer pop handshake, so values advance only when taken;
- a multi-cycle skip-ahead command with busy indication;
- a draw counter.

It sits beside the core as a memory-mapped random source for software and test harnesses.

## Interface
Parameters:
- W, 32: state/output width; only 32 or 64 legal.
- SA, 13: first left-shift amount.
- SB, 17: right-shift amount (use 7 when W=64).
- SC, 5: second left-shift amount (use 17 when W=64).
- SEED, 32'hEBADD4A9 zero-extended to W: reset seed and zero-seed replacement; must be nonzero.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- seed_we  in  1  load seed_in into the state this cycle.
- seed_in  in  W  new seed value.
- rd_en  in  1  consumer pops current value (honoured only when out_valid=1).
- skip_start  in  1  begin skip-ahead of skip_cnt steps.
- skip_cnt  in  16  number of steps to skip.
- out  out  W  current state / random value.
- out_valid  out  1  out is stable and poppable.
- busy  out  1  skip in progress.
- draw_cnt  out  32  count of state advances since reset/seed load, wraps at 2^32.

## Operation
- Step function on state x, all terms truncated to W bits:
  - x1 = x ^ (x << SA)
  - x2 = x1 ^ (x1 >> SB)
  - x3 = x2 ^ (x2 << SC)
  - next state = x3.
- out is the state register directly, with no combinational path from the inputs.
- FSM states:
  - IDLE:
    - out_valid=1, busy=0.
    - rd_en=1: state <= step(state); draw_cnt += 1.
    - skip_start=1 with skip_cnt != 0: latch remaining <= skip_cnt; go SKIP.
    - skip_cnt == 0: skip_start ignored.
  - SKIP:
    - out_valid=0, busy=1.
    - Each cycle: state <= step(state); draw_cnt += 1; remaining -= 1.
    - Go IDLE in the cycle remaining reaches 0, i.e. after exactly skip_cnt steps.
    - rd_en and skip_start are ignored.
- seed_we has the highest priority in any state:
  - state <= (seed_in == 0) ? SEED : seed_in; all-zero state is absorbing and is never allowed.
  - draw_cnt <= 0; remaining <= 0; FSM <= IDLE, aborting any skip.
- Same-cycle priority:
  - seed_we > skip_start > rd_en.
  - In IDLE, rd_en and skip_start in the same cycle start the skip only; the pop is dropped.
- Reset, rst_n=0 at an edge: state=SEED, FSM=IDLE, out_valid=1, busy=0, draw_cnt=0, remaining=0. Reset overrides seed_we.

## Timing
- Pop latency: rd_en sampled at edge k, new out visible after edge k; 1 value per cycle sustained.
- Skip: skip_start at edge k drives busy=1 and out_valid=0 from after edge k. The skip then takes N=skip_cnt cycles:
  - Steps are applied at edges k+1 through k+N.
  - busy=0 and out_valid=1 after edge k+N; out = step^N(initial).
  - The start cycle itself performs no step.
- Seed load: out = loaded value after the same edge; out_valid=1 in the following cycle.
- Mid-skip seed_we or reset: takes effect at that edge; no further steps occur.
- draw_cnt wraps from 0xFFFFFFFF to 0 silently.

## Test plan
- Reset with W=32 defaults -> out=0xEBADD4A9, out_valid=1, busy=0, draw_cnt=0.
- Seed load then pops:
  - seed_we with seed_in=1 -> out=0x00000001.
  - rd_en -> out=0x00042021.
  - rd_en -> out=0x04080601; draw_cnt=2.
- Zero seed: seed_we with seed_in=0 -> out=0xEBADD4A9, draw_cnt=0.
- Skip-ahead:
  - Seed 1, then skip_start with skip_cnt=2, with rd_en held high throughout.
  - busy=1 and out_valid=0 for exactly 2 cycles; rd_en has no effect.
  - Then out=0x04080601, draw_cnt=2.
- Abort and priority:
  - skip_cnt=1000 started; seed_we with seed_in=1 on cycle 10 -> busy=0 next cycle, out=1, draw_cnt=0.
  - skip_start with skip_cnt=0 -> no busy, out unchanged.
  - seed_we with rd_en in the same cycle -> seed wins.
- Bit-accurate scoreboard:
  - W=64, SA/SB/SC = 13/7/17, random seeds.
  - 10k mixed pops and skips checked against a software model of the step function.
  - Reset asserted mid-skip -> state returns to SEED.

Source files
------------

// File: rtl/xorshift_rng.sv
// rtl/xorshift_rng.sv - parametrised xorshift random source with seed load, pop handshake and skip-ahead
// W must be 32 or 64; SEED must be nonzero since the all-zero state is absorbing.
module xorshift_rng #(
    parameter int             W    = 32,
    parameter int             SA   = 13,
    parameter int             SB   = 17,
    parameter int             SC   = 5,
    parameter logic [W-1:0]   SEED = W'(32'hEBADD4A9)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          seed_we,
    input  logic [W-1:0]  seed_in,
    input  logic          rd_en,
    input  logic          skip_start,
    input  logic [15:0]   skip_cnt,
    output logic [W-1:0]  out,
    output logic          out_valid,
    output logic          busy,
    output logic [31:0]   draw_cnt
);

    typedef enum logic {
        S_IDLE,
        S_SKIP
    } state_e;

    state_e        fsm_q, fsm_d;
    logic [W-1:0]  x_q, x_d;
    logic [15:0]   rem_q, rem_d;
    logic [31:0]   cnt_q, cnt_d;

    function automatic logic [W-1:0] step(input logic [W-1:0] x);
        logic [W-1:0] x1;
        logic [W-1:0] x2;
        x1 = x ^ (x << SA);
        x2 = x1 ^ (x1 >> SB);
        return x2 ^ (x2 << SC);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
            x_q   <= SEED;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            x_q   <= x_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        x_d   = x_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        case (fsm_q)
            S_IDLE: begin
                // A skip request swallows a same-cycle pop; the start cycle itself does not step.
                if (skip_start && (skip_cnt != 16'd0)) begin
                    rem_d = skip_cnt;
                    fsm_d = S_SKIP;
                end else if (rd_en) begin
                    x_d   = step(x_q);
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_SKIP: begin
                x_d   = step(x_q);
                cnt_d = cnt_q + 32'd1;
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        if (seed_we) begin
            x_d   = (seed_in == '0) ? SEED : seed_in;
            cnt_d = '0;
            rem_d = '0;
            fsm_d = S_IDLE;
        end
    end

    assign out       = x_q;
    assign out_valid = (fsm_q == S_IDLE);
    assign busy      = (fsm_q == S_SKIP);
    assign draw_cnt  = cnt_q;

endmodule

// File: tb/tb_xorshift_rng.sv
// tb/tb_xorshift_rng.sv - directed and scoreboard checks for xorshift_rng at W=32 and W=64
module tb_xorshift_rng;

    localparam logic [31:0] SEED32 = 32'hEBADD4A9;
    localparam logic [63:0] SEED64 = 64'h00000000EBADD4A9;

    logic        clk = 1'b0;
    logic        rst_n;
    int          tests = 0;
    int          fails = 0;

    logic        a_seed_we, a_rd_en, a_skip_start;
    logic [31:0] a_seed_in;
    logic [15:0] a_skip_cnt;
    logic [31:0] a_out, a_draw_cnt;
    logic        a_out_valid, a_busy;

    logic        b_seed_we, b_rd_en, b_skip_start;
    logic [63:0] b_seed_in;
    logic [15:0] b_skip_cnt;
    logic [63:0] b_out;
    logic [31:0] b_draw_cnt;
    logic        b_out_valid, b_busy;

    always #5 clk = ~clk;

    xorshift_rng u32 (
        .clk(clk), .rst_n(rst_n),
        .seed_we(a_seed_we), .seed_in(a_seed_in),
        .rd_en(a_rd_en), .skip_start(a_skip_start), .skip_cnt(a_skip_cnt),
        .out(a_out), .out_valid(a_out_valid), .busy(a_busy), .draw_cnt(a_draw_cnt)
    );

    xorshift_rng #(.W(64), .SA(13), .SB(7), .SC(17)) u64 (
        .clk(clk), .rst_n(rst_n),
        .seed_we(b_seed_we), .seed_in(b_seed_in),
        .rd_en(b_rd_en), .skip_start(b_skip_start), .skip_cnt(b_skip_cnt),
        .out(b_out), .out_valid(b_out_valid), .busy(b_busy), .draw_cnt(b_draw_cnt)
    );

    function automatic logic [63:0] model_step(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] m_x;
    logic [31:0] m_cnt;
    logic [63:0] s;

    initial begin
        rst_n = 1'b0;
        a_seed_we = 0; a_rd_en = 0; a_skip_start = 0; a_seed_in = '0; a_skip_cnt = '0;
        b_seed_we = 0; b_rd_en = 0; b_skip_start = 0; b_seed_in = '0; b_skip_cnt = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("reset_out", a_out, SEED32);
        check("reset_valid", a_out_valid, 1'b1);
        check("reset_busy", a_busy, 1'b0);
        check("reset_cnt", a_draw_cnt, 32'd0);

        a_seed_we = 1; a_seed_in = 32'd1;
        tick();
        a_seed_we = 0;
        check("seed1_out", a_out, 32'h00000001);
        a_rd_en = 1;
        tick();
        check("pop1_out", a_out, 32'h00042021);
        tick();
        a_rd_en = 0;
        check("pop2_out", a_out, 32'h04080601);
        check("pop2_cnt", a_draw_cnt, 32'd2);

        a_seed_we = 1; a_seed_in = 32'd0;
        tick();
        a_seed_we = 0;
        check("zseed_out", a_out, SEED32);
        check("zseed_cnt", a_draw_cnt, 32'd0);

        a_seed_we = 1; a_seed_in = 32'd1;
        tick();
        a_seed_we = 0;
        a_rd_en = 1; a_skip_start = 1; a_skip_cnt = 16'd2;
        tick();
        a_skip_start = 0;
        check("skip_busy0", a_busy, 1'b1);
        check("skip_valid0", a_out_valid, 1'b0);
        tick();
        check("skip_busy1", a_busy, 1'b1);
        check("skip_valid1", a_out_valid, 1'b0);
        tick();
        a_rd_en = 0;
        check("skip_done_busy", a_busy, 1'b0);
        check("skip_done_valid", a_out_valid, 1'b1);
        check("skip_done_out", a_out, 32'h04080601);
        check("skip_done_cnt", a_draw_cnt, 32'd2);

        a_skip_start = 1; a_skip_cnt = 16'd1000;
        tick();
        a_skip_start = 0;
        repeat (9) tick();
        check("abort_pre_busy", a_busy, 1'b1);
        a_seed_we = 1; a_seed_in = 32'd1;
        tick();
        a_seed_we = 0;
        check("abort_busy", a_busy, 1'b0);
        check("abort_valid", a_out_valid, 1'b1);
        check("abort_out", a_out, 32'h00000001);
        check("abort_cnt", a_draw_cnt, 32'd0);
        tick();
        check("abort_hold_out", a_out, 32'h00000001);

        a_skip_start = 1; a_skip_cnt = 16'd0;
        tick();
        a_skip_start = 0;
        check("skip0_busy", a_busy, 1'b0);
        check("skip0_out", a_out, 32'h00000001);

        a_seed_we = 1; a_seed_in = 32'd5; a_rd_en = 1;
        tick();
        a_seed_we = 0; a_rd_en = 0;
        check("seed_vs_pop_out", a_out, 32'h00000005);
        check("seed_vs_pop_cnt", a_draw_cnt, 32'd0);

        a_seed_we = 1; a_seed_in = 32'd1; a_skip_start = 1; a_skip_cnt = 16'd4;
        tick();
        a_seed_we = 0; a_skip_start = 0;
        check("seed_vs_skip_busy", a_busy, 1'b0);
        check("seed_vs_skip_out", a_out, 32'h00000001);

        check("w64_reset_out", b_out, SEED64);
        m_x = SEED64;
        m_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            int op;
            op = int'($urandom_range(0, 19));
            if (op < 12) begin
                b_rd_en = 1;
                tick();
                b_rd_en = 0;
                m_x = model_step(m_x);
                m_cnt++;
                check("w64_pop", b_out, m_x);
            end else if (op < 15) begin
                tick();
                check("w64_idle", b_out, m_x);
            end else if (op < 19) begin
                int n;
                n = int'($urandom_range(1, 12));
                b_skip_start = 1; b_skip_cnt = 16'(n); b_rd_en = op[0];
                tick();
                b_skip_start = 0;
                check("w64_skip_start_busy", b_busy, 1'b1);
                repeat (n) begin
                    tick();
                    m_x = model_step(m_x);
                    m_cnt++;
                end
                b_rd_en = 0;
                check("w64_skip_busy", b_busy, 1'b0);
                check("w64_skip_out", b_out, m_x);
                check("w64_skip_cnt", b_draw_cnt, m_cnt);
            end else begin
                s = {$urandom, $urandom};
                if ((i % 7) == 0) s = 64'd0;
                b_seed_we = 1; b_seed_in = s;
                tick();
                b_seed_we = 0;
                m_x = (s == 64'd0) ? SEED64 : s;
                m_cnt = 0;
                check("w64_seed_out", b_out, m_x);
                check("w64_seed_cnt", b_draw_cnt, m_cnt);
            end
        end

        b_skip_start = 1; b_skip_cnt = 16'd50;
        tick();
        b_skip_start = 0;
        repeat (5) tick();
        check("w64_midskip_busy", b_busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("w64_rst_out", b_out, SEED64);
        check("w64_rst_busy", b_busy, 1'b0);
        check("w64_rst_cnt", b_draw_cnt, 32'd0);
        tick();
        check("w64_rst_hold", b_out, SEED64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
